// File: rtl/memshare_rqst_profiler_pkg.sv
// Shared memShare configuration: group geometry, DRC indices, bank groups
// and the arrival-tracker entry layout.
package memShare_config_pkg;

    localparam int unsigned SHARE_GROUP_SIZE        = 5;
    localparam logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG = 5'b10101;
    localparam int unsigned RQST_ADDR_BITWIDTH      = 2;
    localparam int unsigned ARR_RQST_TRACK_DEPTH    = 4;
    localparam int unsigned MAX_ALLOC_SEQ_NUM       = 2;
    localparam int unsigned L1PA_REGFILE_ADDR_WIDTH = 5;
    localparam int unsigned MEMSHARE_DRC_NUM        = 3;

    localparam int unsigned NUM_COL_BANKS = 1 << RQST_ADDR_BITWIDTH;
    localparam int unsigned HIT_CNT_W     = $clog2(SHARE_GROUP_SIZE + 1);
    localparam int unsigned TRACK_PTR_W   = $clog2(ARR_RQST_TRACK_DEPTH);
    localparam int unsigned TRACK_CNT_W   = $clog2(ARR_RQST_TRACK_DEPTH + 1);

    typedef enum logic [1:0] {
        DRC1_IDX = 2'd0,
        DRC2_IDX = 2'd1,
        DRC3_IDX = 2'd2
    } memShare_drc_index;

    typedef enum logic {
        GP1_BANK_GRP = 1'b0,
        GP2_BANK_GRP = 1'b1
    } colBank_addr_gropu_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE0,
        ISSUE1
    } profiler_state_e;

    // nseq = 1 means the pattern needs two allocation sequences
    typedef struct packed {
        logic [SHARE_GROUP_SIZE-1:0] flag;
        logic                        nseq;
        logic [MEMSHARE_DRC_NUM-1:0] drc;
    } arr_rqst_entry_t;

    // Even column-bank addresses belong to GP1
    function automatic colBank_addr_gropu_e bank_group(input logic [RQST_ADDR_BITWIDTH-1:0] addr);
        return addr[0] ? GP2_BANK_GRP : GP1_BANK_GRP;
    endfunction

endpackage

// File: rtl/memshare_rqst_profiler_if.sv
// Request-pattern handshake and regFile read bus of the memShare profiler.
interface memshare_rqst_profiler_if;
    import memShare_config_pkg::*;

    logic                                          rqst_valid;
    logic                                          rqst_ready;
    logic [SHARE_GROUP_SIZE-1:0]                   rqst_flag;
    logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr;
    logic                                          pipe_hold;
    logic                                          regfile_ren;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0]            regfile_raddr;
    logic                                          seq_ptr;
    logic [MEMSHARE_DRC_NUM-1:0]                   drc_err;
    logic [TRACK_CNT_W-1:0]                        track_cnt;

    modport slave (
        input  rqst_valid, rqst_flag, rqst_addr, pipe_hold,
        output rqst_ready, regfile_ren, regfile_raddr, seq_ptr, drc_err, track_cnt
    );

    modport master (
        output rqst_valid, rqst_flag, rqst_addr, pipe_hold,
        input  rqst_ready, regfile_ren, regfile_raddr, seq_ptr, drc_err, track_cnt
    );

endinterface

// File: rtl/memshare_drc_classifier.sv
// Combinational shared-column hit counting and memShare DRC flags for one
// incoming request pattern.
module memshare_drc_classifier
    import memShare_config_pkg::*;
(
    input  logic [SHARE_GROUP_SIZE-1:0]                    rqst_flag,
    input  logic [SHARE_GROUP_SIZE*RQST_ADDR_BITWIDTH-1:0] rqst_addr,
    output arr_rqst_entry_t                                entry
);

    logic [HIT_CNT_W-1:0]          hit [NUM_COL_BANKS];
    logic [RQST_ADDR_BITWIDTH-1:0] bank;
    logic                          drc1;
    logic                          drc2;
    logic                          drc3;

    always_comb begin
        for (int unsigned b = 0; b < NUM_COL_BANKS; b++) begin
            hit[b] = '0;
        end
        bank = '0;
        drc2 = 1'b0;
        for (int unsigned i = 0; i < SHARE_GROUP_SIZE; i++) begin
            bank = rqst_addr[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH];
            if (rqst_flag[i]) begin
                if (SHARE_COL_CONFIG[i]) begin
                    hit[bank] = hit[bank] + HIT_CNT_W'(1);
                end else if (bank_group(bank) == GP1_BANK_GRP) begin
                    drc2 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        drc1 = 1'b0;
        drc3 = 1'b0;
        for (int unsigned b = 0; b < NUM_COL_BANKS; b++) begin
            if (hit[b] == HIT_CNT_W'(MAX_ALLOC_SEQ_NUM)) drc1 = 1'b1;
            if (hit[b] >  HIT_CNT_W'(MAX_ALLOC_SEQ_NUM)) drc3 = 1'b1;
        end
    end

    always_comb begin
        entry                = '0;
        entry.flag           = rqst_flag;
        entry.nseq           = drc1;
        entry.drc[DRC1_IDX]  = drc1;
        entry.drc[DRC2_IDX]  = drc2;
        entry.drc[DRC3_IDX]  = drc3;
    end

endmodule

// File: rtl/memshare_rqst_profiler.sv
// memShare request profiler: classifies arriving share-group patterns,
// queues them in the arrival tracker and issues tagged regFile page reads.
module memshare_rqst_profiler
    import memShare_config_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    rst,
    memshare_rqst_profiler_if.slave bus
);

    arr_rqst_entry_t                    in_entry;
    arr_rqst_entry_t                    track_mem [ARR_RQST_TRACK_DEPTH];
    arr_rqst_entry_t                    head;
    logic [TRACK_PTR_W-1:0]             wr_ptr;
    logic [TRACK_PTR_W-1:0]             rd_ptr;
    logic [TRACK_CNT_W-1:0]             count;
    logic                               push;
    logic                               pop;
    profiler_state_e                    state;
    profiler_state_e                    state_next;
    logic                               ren_d,   ren_q;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0] raddr_d, raddr_q;
    logic                               seq_d,   seq_q;
    logic [MEMSHARE_DRC_NUM-1:0]        drc_d,   drc_q;

    memshare_drc_classifier u_classifier (
        .rqst_flag (bus.rqst_flag),
        .rqst_addr (bus.rqst_addr),
        .entry     (in_entry)
    );

    // Ready depends on the registered count only, so a pop while full
    // does not raise it in the same cycle.
    assign bus.rqst_ready = (count < TRACK_CNT_W'(ARR_RQST_TRACK_DEPTH));
    assign push           = bus.rqst_valid && bus.rqst_ready && (bus.rqst_flag != '0);
    assign head           = track_mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (push) track_mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + TRACK_PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + TRACK_PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + TRACK_CNT_W'(1);
                2'b01:   count <= count - TRACK_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // IDLE and ISSUE0 both issue the head as soon as it exists, which
    // gives the one-cycle accept-to-read latency.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        ren_d      = 1'b0;
        raddr_d    = '0;
        seq_d      = 1'b0;
        drc_d      = '0;
        if (!bus.pipe_hold) begin
            case (state)
                IDLE, ISSUE0: begin
                    if (count != '0) begin
                        if (head.drc[DRC2_IDX] || head.drc[DRC3_IDX]) begin
                            drc_d = head.drc;
                            pop   = 1'b1;
                        end else begin
                            ren_d              = 1'b1;
                            raddr_d            = L1PA_REGFILE_ADDR_WIDTH'(head.flag);
                            drc_d[DRC1_IDX]    = head.drc[DRC1_IDX];
                            if (head.nseq) state_next = ISSUE1;
                            else           pop        = 1'b1;
                        end
                    end
                end
                ISSUE1: begin
                    ren_d   = 1'b1;
                    raddr_d = L1PA_REGFILE_ADDR_WIDTH'(head.flag);
                    seq_d   = 1'b1;
                    pop     = 1'b1;
                end
                default: state_next = IDLE;
            endcase
            if (pop) begin
                state_next = ((count == TRACK_CNT_W'(1)) && !push) ? IDLE : ISSUE0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ren_q   <= 1'b0;
            raddr_q <= '0;
            seq_q   <= 1'b0;
            drc_q   <= '0;
        end else begin
            ren_q   <= ren_d;
            raddr_q <= raddr_d;
            seq_q   <= seq_d;
            drc_q   <= drc_d;
        end
    end

    assign bus.regfile_ren   = ren_q;
    assign bus.regfile_raddr = raddr_q;
    assign bus.seq_ptr       = seq_q;
    assign bus.drc_err       = drc_q;
    assign bus.track_cnt     = count;

endmodule

// File: tb/tb_memshare_rqst_profiler.sv
// Scoreboard bench for memshare_rqst_profiler: a behavioural model predicts
// the sequence of read/violation events that a monitor checks.
module tb_memshare_rqst_profiler;

    typedef struct packed {
        logic       ren;
        logic [4:0] raddr;
        logic       seq;
        logic [2:0] drc;
    } ev_t;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    memshare_rqst_profiler_if bus();

    memshare_rqst_profiler dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shared requestors are the even indices; count per bank.
    task automatic model_push(input logic [4:0] f, input logic [9:0] a);
        int hit [4];
        bit d1, d2, d3;
        int b;
        ev_t e;
        if (f == 5'd0) return;
        for (int k = 0; k < 4; k++) hit[k] = 0;
        d1 = 0; d2 = 0; d3 = 0;
        for (int i = 0; i < 5; i++) begin
            if (f[i]) begin
                b = int'(a[2*i +: 2]);
                if (i % 2 == 0)            hit[b] = hit[b] + 1;
                else if (b == 0 || b == 2) d2 = 1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (hit[k] == 2) d1 = 1;
            if (hit[k] >= 3) d3 = 1;
        end
        if (d2 || d3) begin
            e = '{ren: 1'b0, raddr: 5'd0, seq: 1'b0, drc: {d3, d2, d1}};
            exp_q.push_back(e);
        end else begin
            e = '{ren: 1'b1, raddr: f, seq: 1'b0, drc: {2'b00, d1}};
            exp_q.push_back(e);
            if (d1) begin
                e = '{ren: 1'b1, raddr: f, seq: 1'b1, drc: 3'b000};
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge sys_clk) begin
        ev_t act;
        if (!rst && (bus.regfile_ren || bus.drc_err != 3'b000)) begin
            act = '{ren: bus.regfile_ren, raddr: bus.regfile_raddr,
                    seq: bus.seq_ptr, drc: bus.drc_err};
            if (exp_q.size() == 0) chk("unexpected_output", 32'(act), 32'd0);
            else                   chk("read_event", 32'(act), 32'(exp_q.pop_front()));
        end
    end

    // Called just after a rising edge; returns just after the next one.
    task automatic send(input logic [4:0] f, input logic [9:0] a, output bit acc);
        bus.rqst_valid = 1'b1;
        bus.rqst_flag  = f;
        bus.rqst_addr  = a;
        @(negedge sys_clk);
        acc = bus.rqst_ready;
        @(posedge sys_clk);
        if (acc) model_push(f, a);
        #1;
        bus.rqst_valid = 1'b0;
        bus.rqst_flag  = '0;
        bus.rqst_addr  = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && !(exp_q.size() == 0 && bus.track_cnt == 3'd0); i++)
            @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_track_cnt"}, 32'(bus.track_cnt), 32'd0);
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        bit acc;
        logic [4:0] rf;
        logic [9:0] ra;

        bus.rqst_valid = 1'b0;
        bus.rqst_flag  = '0;
        bus.rqst_addr  = '0;
        bus.pipe_hold  = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("reset_ren",   32'(bus.regfile_ren),   32'd0);
        chk("reset_raddr", 32'(bus.regfile_raddr), 32'd0);
        chk("reset_seq",   32'(bus.seq_ptr),       32'd0);
        chk("reset_drc",   32'(bus.drc_err),       32'd0);
        chk("reset_cnt",   32'(bus.track_cnt),     32'd0);
        chk("reset_ready", 32'(bus.rqst_ready),    32'd1);
        @(posedge sys_clk);
        #1 rst = 1'b0;

        // Single sequence: first read one cycle after acceptance
        send(5'b00101, 10'b00_00_10_00_00, acc);
        chk("single_accept", 32'(acc), 32'd1);
        @(negedge sys_clk);
        chk("single_pre_ren", 32'(bus.regfile_ren), 32'd0);
        @(negedge sys_clk);
        chk("single_ren",   32'(bus.regfile_ren),   32'd1);
        chk("single_raddr", 32'(bus.regfile_raddr), 32'd5);
        @(negedge sys_clk);
        chk("single_after_ren", 32'(bus.regfile_ren), 32'd0);
        drain("single");

        // Two sequences (DRC1), DRC3 skip, DRC2 skip, zero flag discarded
        send(5'b10101, 10'b11_00_01_00_01, acc);
        drain("drc1");
        send(5'b10101, 10'b11_00_11_00_11, acc);
        drain("drc3");
        send(5'b00010, 10'b00_00_00_00_00, acc);
        drain("drc2");
        send(5'b00000, 10'b11_11_11_11_11, acc);
        @(negedge sys_clk);
        chk("zero_flag_cnt", 32'(bus.track_cnt), 32'd0);
        drain("zero_flag");

        // Full tracker under hold
        bus.pipe_hold = 1'b1;
        send(5'b00101, 10'b00_00_10_00_00, acc);
        for (int i = 0; i < 3; i++) send(5'($urandom_range(1, 31)), 10'($urandom), acc);
        chk("full_cnt",   32'(bus.track_cnt),  32'd4);
        chk("full_ready", 32'(bus.rqst_ready), 32'd0);
        send(5'b00101, 10'b00_00_10_00_00, acc);
        chk("fifth_rejected", 32'(acc), 32'd0);
        chk("full_cnt_hold", 32'(bus.track_cnt), 32'd4);
        bus.pipe_hold = 1'b0;
        @(negedge sys_clk);
        chk("ready_same_cycle_pop", 32'(bus.rqst_ready), 32'd0);
        @(negedge sys_clk);
        chk("ready_after_pop", 32'(bus.rqst_ready), 32'd1);
        drain("full");

        // Hold during the second sequence
        send(5'b10101, 10'b11_00_01_00_01, acc);
        @(posedge sys_clk);
        #1 bus.pipe_hold = 1'b1;
        @(negedge sys_clk);
        chk("hold_seq0_ren", 32'(bus.regfile_ren), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            chk("hold_ren_low", 32'(bus.regfile_ren), 32'd0);
        end
        #1 bus.pipe_hold = 1'b0;
        @(negedge sys_clk);
        chk("hold_release_ren", 32'(bus.regfile_ren), 32'd1);
        chk("hold_release_seq", 32'(bus.seq_ptr),     32'd1);
        drain("hold_mid");

        // Reset during the second sequence with three patterns queued
        bus.pipe_hold = 1'b1;
        send(5'b10101, 10'b11_00_01_00_01, acc);
        send(5'b00101, 10'b00_00_10_00_00, acc);
        send(5'b00001, 10'b00_00_00_00_01, acc);
        bus.pipe_hold = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(negedge sys_clk);
        chk("midrst_ren",   32'(bus.regfile_ren), 32'd0);
        chk("midrst_cnt",   32'(bus.track_cnt),   32'd0);
        chk("midrst_ready", 32'(bus.rqst_ready),  32'd1);
        @(posedge sys_clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            chk("midrst_no_read", 32'(bus.regfile_ren), 32'd0);
        end
        drain("midrst");

        // Randomised traffic with random stalls
        for (int k = 0; k < 150; k++) begin
            bus.pipe_hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) begin
                rf = 5'($urandom);
                ra = 10'($urandom);
                send(rf, ra, acc);
            end else begin
                @(posedge sys_clk);
                #1;
            end
        end
        bus.pipe_hold = 1'b0;
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
